// File: rtl/rt_pkg.sv
// Shared types for the memory port arbiter: arbiter FSM states and the
// width-independent control parts of the request and response.
package rt_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Control part of the selected request; addr/wdata/be are forwarded as
    // plain vectors because their widths are module parameters.
    typedef struct packed {
        logic valid;
        logic we;
        logic lock;
    } req_ctrl_t;

    typedef struct packed {
        logic valid;
        logic err;
    } rsp_ctrl_t;

endpackage

// File: rtl/mem_port_arb_idfifo.sv
// In-order FIFO of requester indices for accepted-but-unanswered transactions.
module mem_port_arb_idfifo #(
    parameter int Depth = 4,
    parameter int Width = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_id,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head_id
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] id_mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_id = id_mem[rd_ptr];

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) id_mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mem_port_arb.sv
// Round-robin arbiter with burst locking, merging NumReq requesters onto one
// memory port; in-order responses are steered back via an ID FIFO.
module mem_port_arb
    import rt_pkg::*;
#(
    parameter int NumReq         = 3,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             lock_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    input  logic [NumReq*DataWidth/8-1:0] be_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [NumReq-1:0]             err_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    output logic [DataWidth/8-1:0]        mem_be_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic                          mem_err_i,
    input  logic [DataWidth-1:0]          mem_rdata_i,
    output logic                          spurious_o
);

    localparam int IdxW = $clog2(NumReq);
    localparam int BeW  = DataWidth / 8;

    arb_state_e      state, state_nxt;
    logic [IdxW-1:0] owner, owner_nxt;
    logic [IdxW-1:0] rr_ptr;
    logic [NumReq-1:0] eligible;
    logic [IdxW-1:0] sel_idx;
    req_ctrl_t       sel_ctrl;
    rsp_ctrl_t       rsp;
    logic            accept;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IdxW-1:0] head_id;

    // While locked only the owner may be granted, even if it is idle.
    always_comb begin
        if (state == ARB_LOCKED) eligible = req_i & (NumReq'(1) << owner);
        else                     eligible = req_i;
    end

    always_comb begin
        int cand;
        cand           = 0;
        sel_idx        = '0;
        sel_ctrl.valid = 1'b0;
        for (int off = 1; off <= NumReq; off++) begin
            cand = (int'(rr_ptr) + off) % NumReq;
            if (!sel_ctrl.valid && eligible[cand]) begin
                sel_ctrl.valid = 1'b1;
                sel_idx        = IdxW'(cand);
            end
        end
        sel_ctrl.we   = we_i[sel_idx];
        sel_ctrl.lock = lock_i[sel_idx];
    end

    // A full FIFO blocks requests without looking at mem_rvalid_i, keeping
    // the response path free of any combinational loop into mem_req_o.
    assign mem_req_o   = sel_ctrl.valid & ~fifo_full & rst_n;
    assign accept      = mem_req_o & mem_gnt_i;
    assign gnt_o       = accept ? (NumReq'(1) << sel_idx) : '0;
    assign mem_we_o    = sel_ctrl.we;
    assign mem_addr_o  = addr_i[sel_idx*AddrWidth +: AddrWidth];
    assign mem_wdata_o = wdata_i[sel_idx*DataWidth +: DataWidth];
    assign mem_be_o    = be_i[sel_idx*BeW +: BeW];

    assign rsp.valid = mem_rvalid_i & ~fifo_empty & rst_n;
    assign rsp.err   = mem_err_i;
    assign rvalid_o  = rsp.valid ? (NumReq'(1) << head_id) : '0;
    assign err_o     = (rsp.valid & rsp.err) ? (NumReq'(1) << head_id) : '0;
    assign rdata_o   = mem_rdata_i;

    mem_port_arb_idfifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_idfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept),
        .push_id (sel_idx),
        .pop     (mem_rvalid_i),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head_id (head_id)
    );

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            ARB_IDLE: begin
                if (accept && sel_ctrl.lock) begin
                    state_nxt = ARB_LOCKED;
                    owner_nxt = sel_idx;
                end
            end
            ARB_LOCKED: begin
                if (!lock_i[owner]) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // rr_ptr resets to the last index so requester 0 wins the first search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            rr_ptr     <= IdxW'(NumReq - 1);
            spurious_o <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (accept) rr_ptr <= sel_idx;
            if (mem_rvalid_i && fifo_empty) spurious_o <= 1'b1;
        end
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter NumReq, default 3, number of requester ports (2..8).
REQ-002 SHALL have parameter AddrWidth, default 32, address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width; byte enable width is DataWidth/8.
REQ-004 SHALL have parameter MaxOutstanding, default 4, accepted-but-unanswered transactions allowed (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports req_i / lock_i / we_i  input  NumReq  per-requester request, burst lock, write enable.
REQ-008 SHALL have ports addr_i  input  NumReq x AddrWidth; wdata_i  input  NumReq x DataWidth; be_i  input  NumReq x DataWidth/8.
REQ-009 SHALL have ports gnt_o / rvalid_o / err_o  output  NumReq  per-requester grant, response valid, response error.
REQ-010 SHALL have port rdata_o  output  DataWidth  response data, shared by all requesters, qualified by rvalid_o.
REQ-011 SHALL have downstream ports mem_req_o, mem_we_o (output 1), mem_addr_o, mem_wdata_o, mem_be_o (output, widths as above), mem_gnt_i, mem_rvalid_i, mem_err_i (input 1), mem_rdata_i (input DataWidth).
REQ-012 SHALL have port spurious_o  output  1  sticky flag: response received with no outstanding transaction.

Function
REQ-013 Request path SHALL be combinational: selected requester's addr/we/be/wdata forwarded to mem_* in the same cycle; gnt_o[i] = selected(i) & mem_req_o & mem_gnt_i.
REQ-014 Handshake: a transaction is accepted in a cycle with mem_req_o & mem_gnt_i; a requester SHALL hold req_i and payload stable until its gnt_o is high.
REQ-015 Arbitration SHALL be round-robin: search starts at index rr_ptr+1 modulo NumReq; rr_ptr updates to the granted index only on acceptance.
REQ-016 Arbiter states: IDLE (round-robin) and LOCKED(owner); IDLE->LOCKED on acceptance with lock_i[owner]=1; LOCKED->IDLE on first cycle lock_i[owner]=0; in LOCKED only owner is eligible, others are stalled even if owner has no req_i.
REQ-017 Each acceptance SHALL push the granted index into an in-order ID FIFO of depth MaxOutstanding; each mem_rvalid_i SHALL pop it.
REQ-018 Responses SHALL be in order: rvalid_o[head]=mem_rvalid_i, err_o[head]=mem_err_i, rdata_o=mem_rdata_i, same cycle (zero latency); all other rvalid_o bits 0.
REQ-019 FIFO full: mem_req_o SHALL be 0 regardless of requests, even if mem_rvalid_i pops in the same cycle (no rvalid->req combinational path).
REQ-020 Simultaneous push and pop when not full: both SHALL occur, count unchanged.
REQ-021 mem_rvalid_i with FIFO empty: no rvalid_o asserted, spurious_o set and held until reset.
REQ-022 Writes SHALL also occupy a FIFO slot and receive a response (write acknowledge).
REQ-023 Count and pointers SHALL wrap modulo MaxOutstanding; count width $clog2(MaxOutstanding)+1.

Reset
REQ-024 On rst_n low: FIFO emptied, count 0, rr_ptr = NumReq-1 (requester 0 wins first), state IDLE, spurious_o 0.
REQ-025 Reset values: mem_req_o 0, gnt_o 0, rvalid_o 0, err_o 0; data outputs don't-care but not X-propagating into valids.
REQ-026 Reset mid-operation SHALL discard outstanding IDs; responses arriving after release with empty FIFO set spurious_o.

Structure
REQ-027 Shared typedefs (request payload struct, response struct) SHALL live in rt_pkg; parameters remain module-local.
REQ-028 ID FIFO SHALL be a sub-module mem_port_arb_idfifo (depth, width $clog2(NumReq)); arbiter FSM and round-robin in top.

Verification
REQ-029 Reset release, req_i=3'b111, mem_gnt_i=1 always -> grants 0,1,2,0 on consecutive cycles.
REQ-030 Requester 1 lock_i=1 for 4 accepted writes, req_i[0,2] held -> only gnt_o[1] for 4 grants, then requester 2 granted.
REQ-031 MaxOutstanding=4, mem_rvalid_i=0, continuous requests -> exactly 4 acceptances, mem_req_o 0 thereafter; one rvalid -> one more acceptance next cycle.
REQ-032 Reads by 2 then 0, responses 0xDEAD_BEEF then 0x1234_5678 -> rvalid_o[2] with 0xDEAD_BEEF, then rvalid_o[0] with 0x1234_5678.
REQ-033 mem_err_i=1 on response for requester 1 -> err_o[1]=1 with rvalid_o[1] same cycle.
REQ-034 rst_n pulsed with 3 outstanding, then mem_rvalid_i pulse -> no rvalid_o, spurious_o=1.
